// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: moves one frame of real samples into the FFT core, starts
// it, streams the complex bins back out and reports the strongest bin of the
// lower half spectrum (DC excluded) for the tuner display.
//
// state  | meaning
// IDLE   | waiting for arm, or continuous to re-arm
// LOAD   | accepting samples and writing them to the core
// START  | one-cycle start pulse to the core
// WAIT   | waiting for done, bounded by DONE_TIMEOUT
// UNLOAD | one bin per done cycle, tracking the peak
// REPORT | peak published, result_valid pulse
module fft_frame_sequencer #(
  parameter int N            = 512,
  parameter int DW           = 16,
  parameter int AW           = $clog2(N),
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic            slow_clk,
  input  logic            reset,
  input  logic            continuous,
  input  logic            arm,
  input  logic            sample_valid,
  input  logic [DW-1:0]   sample_in,
  output logic            sample_ready,
  output logic            fft_load,
  output logic [AW-1:0]   fft_load_adr,
  output logic [2*DW-1:0] fft_data_in,
  output logic            fft_start,
  input  logic            fft_done,
  input  logic [2*DW-1:0] fft_data_out,
  output logic [AW-1:0]   peak_bin,
  output logic [DW:0]     peak_mag,
  output logic            result_valid,
  output logic            busy,
  output logic            overrun,
  output logic            timeout_err
);

  localparam int WCW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]  load_cnt, out_cnt, best_bin;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [DW:0]    best_mag, re_ext, im_ext, abs_re, abs_im, mag;
  logic           accept, last_load, timed_out, last_bin, in_search, entering_load;

  assign accept        = (state == S_LOAD) && sample_valid;
  assign last_load     = accept && (load_cnt == AW'(N - 1));
  assign wait_nxt      = wait_cnt + 1'b1;
  // Timeout fires when the count is about to reach DONE_TIMEOUT-1, so the whole
  // start-to-abort window is DONE_TIMEOUT cycles including the start pulse.
  assign timed_out     = (state == S_WAIT) && !fft_done && (wait_nxt == WCW'(DONE_TIMEOUT - 1));
  assign last_bin      = (state == S_UNLOAD) && fft_done && (out_cnt == AW'(N - 1));
  // Only bins 1..N/2-1 are meaningful for a real input: skip DC and the mirror half.
  assign in_search     = (out_cnt != '0) && (out_cnt < AW'(N / 2));
  assign entering_load = (state_next == S_LOAD) && (state != S_LOAD);

  // Magnitude |re|+|im| in DW+1 bits so the most negative value is exact.
  assign re_ext = {fft_data_out[2*DW-1], fft_data_out[2*DW-1:DW]};
  assign im_ext = {fft_data_out[DW-1], fft_data_out[DW-1:0]};
  assign abs_re = re_ext[DW] ? (~re_ext + 1'b1) : re_ext;
  assign abs_im = im_ext[DW] ? (~im_ext + 1'b1) : im_ext;
  assign mag    = abs_re + abs_im;

  // State register.
  always_ff @(posedge slow_clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (arm || continuous) state_next = S_LOAD;
      S_LOAD:   if (last_load) state_next = S_START;
      S_START:  state_next = S_WAIT;
      S_WAIT: begin
        if (fft_done)       state_next = S_UNLOAD;
        else if (timed_out) state_next = S_IDLE;
      end
      S_UNLOAD: if (last_bin) state_next = S_REPORT;
      S_REPORT: state_next = continuous ? S_LOAD : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Counters, peak search, published results and sticky error flags.
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      load_cnt    <= '0;
      wait_cnt    <= '0;
      out_cnt     <= '0;
      best_mag    <= '0;
      best_bin    <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (entering_load) begin
        load_cnt    <= '0;
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (accept) load_cnt <= load_cnt + 1'b1;
        if (sample_valid && !sample_ready && state != S_IDLE) overrun <= 1'b1;
        if (timed_out) timeout_err <= 1'b1;
      end

      if (state == S_START)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_nxt;

      // The done cycle seen in WAIT carries bin 0 (DC), so counting resumes at 1.
      if (state == S_WAIT && fft_done) begin
        out_cnt  <= AW'(1);
        best_mag <= '0;
        best_bin <= AW'(1);
      end else if (state == S_UNLOAD && fft_done) begin
        out_cnt <= out_cnt + 1'b1;
        if (in_search && mag > best_mag) begin
          best_mag <= mag;
          best_bin <= out_cnt;
        end
      end

      // The last bin lies outside the search range, so best_* is final here and
      // the published values line up with the result_valid pulse in REPORT.
      if (last_bin) begin
        peak_bin <= best_bin;
        peak_mag <= best_mag;
      end
    end
  end

  // Moore/Mealy outputs; everything idles at zero.
  always_comb begin
    sample_ready = (state == S_LOAD);
    fft_load     = accept;
    fft_load_adr = accept ? load_cnt : '0;
    fft_data_in  = accept ? {sample_in, {DW{1'b0}}} : '0;
    fft_start    = (state == S_START);
    result_valid = (state == S_REPORT);
    busy         = (state != S_IDLE);
  end

endmodule
